// File: rtl/x2050_chan_pkg.sv
// Shared definitions for the 2050 channel command responder.
// Covers condition codes, routine request codes and the responder state encoding.
package x2050_chan_pkg;

    localparam logic [1:0] CC_OK     = 2'd0;
    localparam logic [1:0] CC_STATUS = 2'd1;
    localparam logic [1:0] CC_BUSY   = 2'd2;
    localparam logic [1:0] CC_NOTOP  = 2'd3;

    localparam logic [3:0] RT_NONE        = 4'd0;
    localparam logic [3:0] RT_END_CODE    = 4'd2;
    localparam logic [3:0] RT_TIMEOUT_CODE = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_REPLY = 2'd2
    } chan_state_e;

    // A well-formed command has exactly one command bit set.
    function automatic logic is_one_hot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/x2050chrsp_rtq.sv
// Two-deep routine request queue toward the CPU ROS.
// The head entry is presented until the ROS advance accepts it.
module x2050rtq
    import x2050_chan_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_post,
    input  logic [3:0] i_code,
    input  logic       i_ros_advance,
    output logic [3:0] o_routine_requesting,
    output logic       o_routine_recd
);

    logic [3:0] head_q, head_d;
    logic [3:0] tail_q, tail_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        // Acceptance frees a slot before a same-cycle post is placed.
        if (i_ros_advance && (cnt_q != 2'd0)) begin
            head_d = tail_q;
            tail_d = RT_NONE;
            cnt_d  = cnt_q - 2'd1;
        end
        if (i_post) begin
            if (cnt_d == 2'd0) begin
                head_d = i_code;
                cnt_d  = 2'd1;
            end else if (cnt_d == 2'd1) begin
                tail_d = i_code;
                cnt_d  = 2'd2;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head_q <= RT_NONE;
            tail_q <= RT_NONE;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_routine_requesting = head_q;
    assign o_routine_recd       = (cnt_q != 2'd0);

endmodule

// File: rtl/x2050chrsp.sv
// Channel-side command responder: answers I/O commands with a condition code,
// tracks one subchannel busy/interrupt state and posts routine requests.
module x2050chrsp
    import x2050_chan_pkg::*;
#(
    parameter logic [2:0]  CH_ID          = 3'd0,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
    parameter logic [3:0]  RT_END         = 4'd2,
    parameter logic [3:0]  RT_TIMEOUT     = 4'd3
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_cmd_strobe,
    input  logic [2:0] i_ch_select,
    input  logic       i_start_io,
    input  logic       i_halt_io,
    input  logic       i_test_io,
    input  logic       i_test_channel,
    input  logic       i_int_test_io,
    input  logic       i_ros_advance,
    input  logic       i_dev_done,
    output logic       o_reply_latch_pulse,
    output logic [1:0] o_cc,
    output logic [3:0] o_routine_requesting,
    output logic       o_routine_recd,
    output logic       o_busy,
    output logic       o_int_pending,
    output logic       o_timeout_check
);

    chan_state_e state_q, state_d;
    logic        busy_q, busy_d;
    logic        ip_q, ip_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  cc_q, cc_d;
    logic        timeout_q, timeout_d;

    logic        cmd_sel;
    logic [4:0]  cmd_vec;
    logic        done_ev;
    logic        to_ev;
    logic        start_ok;
    logic        post;
    logic [3:0]  post_code;

    assign cmd_vec = {i_start_io, i_halt_io, i_test_io, i_test_channel, i_int_test_io};
    assign cmd_sel = i_cmd_strobe && (i_ch_select == CH_ID);

    always_comb begin
        busy_d    = busy_q;
        ip_d      = ip_q;
        cc_d      = CC_OK;
        start_ok  = 1'b0;
        post      = 1'b0;
        post_code = RT_END;

        done_ev = i_dev_done && busy_q;
        to_ev   = busy_q && (cnt_q == (TIMEOUT_CYCLES - 16'd1)) && !done_ev;

        // Completion is applied first; any command sees the post-completion state.
        if (done_ev) begin
            busy_d    = 1'b0;
            ip_d      = 1'b1;
            post      = 1'b1;
            post_code = RT_END;
        end else if (to_ev) begin
            busy_d    = 1'b0;
            ip_d      = 1'b1;
            post      = 1'b1;
            post_code = RT_TIMEOUT;
        end
        timeout_d = to_ev;

        if (cmd_sel) begin
            if (!is_one_hot(cmd_vec)) begin
                cc_d = CC_NOTOP;
            end else if (i_start_io) begin
                if (busy_d) begin
                    cc_d = CC_BUSY;
                end else if (ip_d) begin
                    cc_d = CC_STATUS;
                end else begin
                    cc_d     = CC_OK;
                    busy_d   = 1'b1;
                    start_ok = 1'b1;
                end
            end else if (i_halt_io) begin
                // A halt racing a completion still reports the operation as ended.
                if (busy_q) begin
                    busy_d = 1'b0;
                    ip_d   = 1'b1;
                    cc_d   = CC_STATUS;
                end
            end else if (i_test_io || i_test_channel) begin
                if (ip_d) begin
                    cc_d = CC_STATUS;
                    if (i_test_io) begin
                        ip_d = 1'b0;
                    end
                end else if (busy_d) begin
                    cc_d = CC_BUSY;
                end
            end else begin
                if (ip_d) begin
                    cc_d = CC_STATUS;
                    ip_d = 1'b0;
                end
            end
        end

        if (start_ok) begin
            cnt_d = 16'd0;
        end else if (busy_d) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end

        if (cmd_sel) begin
            state_d = ST_REPLY;
        end else if (busy_d) begin
            state_d = ST_BUSY;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            ip_q      <= 1'b0;
            cnt_q     <= 16'd0;
            cc_q      <= CC_OK;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            ip_q      <= ip_d;
            cnt_q     <= cnt_d;
            cc_q      <= cc_d;
            timeout_q <= timeout_d;
        end
    end

    x2050rtq u_rtq (
        .i_clk               (i_clk),
        .i_reset_n           (i_reset_n),
        .i_post              (post),
        .i_code              (post_code),
        .i_ros_advance       (i_ros_advance),
        .o_routine_requesting(o_routine_requesting),
        .o_routine_recd      (o_routine_recd)
    );

    assign o_reply_latch_pulse = (state_q == ST_REPLY);
    assign o_cc                = cc_q;
    assign o_busy              = busy_q;
    assign o_int_pending       = ip_q;
    assign o_timeout_check     = timeout_q;

endmodule

// File: tb/tb_x2050chrsp.sv
// Self-checking bench for x2050chrsp: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_x2050chrsp;

    localparam int TMO = 255;
    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_START = 5'b10000;
    localparam logic [4:0] C_HALT  = 5'b01000;
    localparam logic [4:0] C_TIO   = 5'b00100;
    localparam logic [4:0] C_TCH   = 5'b00010;
    localparam logic [4:0] C_ITIO  = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       strobe;
    logic [2:0] sel;
    logic [4:0] cmd;
    logic       done, adv;
    logic       o_pulse, o_recd, o_busy, o_ip, o_to;
    logic [1:0] o_cc;
    logic [3:0] o_rt;

    always #5 clk = ~clk;

    x2050chrsp #(
        .CH_ID(3'd0), .TIMEOUT_CYCLES(16'd255), .RT_END(4'd2), .RT_TIMEOUT(4'd3)
    ) dut (
        .i_clk               (clk),
        .i_reset_n           (rst_n),
        .i_cmd_strobe        (strobe),
        .i_ch_select         (sel),
        .i_start_io          (cmd[4]),
        .i_halt_io           (cmd[3]),
        .i_test_io           (cmd[2]),
        .i_test_channel      (cmd[1]),
        .i_int_test_io       (cmd[0]),
        .i_ros_advance       (adv),
        .i_dev_done          (done),
        .o_reply_latch_pulse (o_pulse),
        .o_cc                (o_cc),
        .o_routine_requesting(o_rt),
        .o_routine_recd      (o_recd),
        .o_busy              (o_busy),
        .o_int_pending       (o_ip),
        .o_timeout_check     (o_to)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: busy window measured in clock edges since start.
    int cyc;
    int m_start_cyc;
    bit m_busy, m_ip, m_pulse, m_to;
    int m_cc;
    int m_q[$];

    typedef struct {
        bit         stb;
        logic [2:0] sel;
        logic [4:0] cmd;
        bit         done;
        bit         adv;
        bit         e_pulse;
        int         e_cc;
        bit         e_busy;
        bit         e_ip;
        int         e_rt;
        bit         e_recd;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        m_start_cyc = 0;
        m_busy = 0; m_ip = 0; m_pulse = 0; m_to = 0; m_cc = 0;
        m_q.delete();
    endtask

    task automatic model_step(input bit stb, input logic [2:0] s, input logic [4:0] c,
                              input bit d, input bit a);
        bit done_ev, to_ev, was_busy;
        cyc++;
        was_busy = m_busy;
        done_ev  = d && m_busy;
        to_ev    = m_busy && ((cyc - m_start_cyc) == TMO) && !done_ev;
        if (a && m_q.size() > 0) void'(m_q.pop_front());
        if (done_ev || to_ev) begin
            m_busy = 0;
            m_ip   = 1;
            if (m_q.size() < 2) m_q.push_back(done_ev ? 2 : 3);
        end
        m_to = to_ev;
        m_pulse = 0;
        m_cc = 0;
        if (stb && s == 3'd0) begin
            m_pulse = 1;
            if ($countones(c) != 1) m_cc = 3;
            else if (c[4]) begin
                if (m_busy) m_cc = 2;
                else if (m_ip) m_cc = 1;
                else begin m_busy = 1; m_start_cyc = cyc; end
            end else if (c[3]) begin
                if (was_busy) begin m_busy = 0; m_ip = 1; m_cc = 1; end
            end else if (c[2] || c[1]) begin
                if (m_ip) begin m_cc = 1; if (c[2]) m_ip = 0; end
                else if (m_busy) m_cc = 2;
            end else begin
                if (m_ip) begin m_cc = 1; m_ip = 0; end
            end
        end
    endtask

    task automatic step(input bit stb, input logic [2:0] s, input logic [4:0] c,
                        input bit d, input bit a);
        @(negedge clk);
        strobe = stb; sel = s; cmd = c; done = d; adv = a;
        @(posedge clk);
        model_step(stb, s, c, d, a);
        #1;
        chk("reply_pulse", o_pulse, m_pulse);
        if (m_pulse) chk("cc", o_cc, m_cc);
        chk("busy", o_busy, m_busy);
        chk("int_pending", o_ip, m_ip);
        chk("timeout_check", o_to, m_to);
        chk("routine_code", o_rt, (m_q.size() > 0) ? m_q[0] : 0);
        chk("routine_recd", o_recd, (m_q.size() > 0) ? 1 : 0);
    endtask

    task automatic add(input bit stb, input logic [2:0] s, input logic [4:0] c, input bit d,
                       input bit a, input bit ep, input int ecc, input bit eb, input bit eip,
                       input int ert, input bit erecd);
        vec_t v;
        v.stb = stb; v.sel = s; v.cmd = c; v.done = d; v.adv = a;
        v.e_pulse = ep; v.e_cc = ecc; v.e_busy = eb; v.e_ip = eip; v.e_rt = ert; v.e_recd = erecd;
        tbl.push_back(v);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pulse"}, o_pulse, 0);
        chk({tag, "_cc"}, o_cc, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_ip"}, o_ip, 0);
        chk({tag, "_to"}, o_to, 0);
        chk({tag, "_rt"}, o_rt, 0);
        chk({tag, "_recd"}, o_recd, 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; strobe = 0; sel = 0; cmd = C_NONE; done = 0; adv = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        //      stb sel   cmd             d  a   pulse cc busy ip rt recd
        add(0, 3'd0, C_NONE,          0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 3'd0, C_START,         0, 0,  1, 0, 1, 0, 0, 0);
        add(1, 3'd0, C_START,         0, 0,  1, 2, 1, 0, 0, 0);
        add(0, 3'd0, C_NONE,          1, 0,  0, 0, 0, 1, 2, 1);
        add(0, 3'd0, C_NONE,          0, 1,  0, 0, 0, 1, 0, 0);
        add(1, 3'd0, C_TIO,           0, 0,  1, 1, 0, 0, 0, 0);
        add(1, 3'd0, C_TCH,           0, 0,  1, 0, 0, 0, 0, 0);
        add(1, 3'd3, C_START,         0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 3'd0, C_START|C_HALT,  0, 0,  1, 3, 0, 0, 0, 0);
        add(1, 3'd0, C_NONE,          0, 0,  1, 3, 0, 0, 0, 0);
        add(1, 3'd0, C_START,         0, 0,  1, 0, 1, 0, 0, 0);
        add(1, 3'd0, C_TCH,           0, 0,  1, 2, 1, 0, 0, 0);
        add(1, 3'd0, C_HALT,          0, 0,  1, 1, 0, 1, 0, 0);
        add(1, 3'd0, C_TCH,           0, 0,  1, 1, 0, 1, 0, 0);
        add(1, 3'd0, C_START,         0, 0,  1, 1, 0, 1, 0, 0);
        add(1, 3'd0, C_ITIO,          0, 0,  1, 1, 0, 0, 0, 0);
        add(1, 3'd0, C_ITIO,          0, 0,  1, 0, 0, 0, 0, 0);
        add(1, 3'd0, C_START,         0, 0,  1, 0, 1, 0, 0, 0);
        add(1, 3'd0, C_START,         1, 0,  1, 1, 0, 1, 2, 1);
        add(1, 3'd0, C_ITIO,          0, 0,  1, 1, 0, 0, 2, 1);
        add(1, 3'd0, C_START,         0, 0,  1, 0, 1, 0, 2, 1);
        add(0, 3'd0, C_NONE,          1, 0,  0, 0, 0, 1, 2, 1);
        add(0, 3'd0, C_NONE,          0, 1,  0, 0, 0, 1, 2, 1);
        add(0, 3'd0, C_NONE,          0, 1,  0, 0, 0, 1, 0, 0);
        add(1, 3'd0, C_ITIO,          0, 0,  1, 1, 0, 0, 0, 0);
        add(1, 3'd0, C_START,         0, 0,  1, 0, 1, 0, 0, 0);
        add(1, 3'd0, C_HALT,          1, 0,  1, 1, 0, 1, 2, 1);
        add(0, 3'd0, C_NONE,          0, 1,  0, 0, 0, 1, 0, 0);
        add(1, 3'd0, C_ITIO,          0, 0,  1, 1, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].stb, tbl[i].sel, tbl[i].cmd, tbl[i].done, tbl[i].adv);
            chk($sformatf("vec%0d_pulse", i), o_pulse, tbl[i].e_pulse);
            if (tbl[i].e_pulse) chk($sformatf("vec%0d_cc", i), o_cc, tbl[i].e_cc);
            chk($sformatf("vec%0d_busy", i), o_busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_ip", i), o_ip, tbl[i].e_ip);
            chk($sformatf("vec%0d_rt", i), o_rt, tbl[i].e_rt);
            chk($sformatf("vec%0d_recd", i), o_recd, tbl[i].e_recd);
        end

        // Timeout: pulse exactly TMO cycles after the start reply.
        step(1, 3'd0, C_START, 0, 0);
        k = 1;
        while (k <= 400) begin
            step(0, 3'd0, C_NONE, 0, 0);
            if (o_to) break;
            k++;
        end
        chk("timeout_cycle", k, TMO);
        chk("timeout_code", o_rt, 3);
        chk("timeout_busy", o_busy, 0);
        step(0, 3'd0, C_NONE, 0, 0);
        chk("timeout_single", o_to, 0);
        step(0, 3'd0, C_NONE, 0, 1);
        step(1, 3'd0, C_ITIO, 0, 0);

        // Done coinciding with the timeout edge: RT_END only.
        step(1, 3'd0, C_START, 0, 0);
        repeat (TMO - 1) step(0, 3'd0, C_NONE, 0, 0);
        step(0, 3'd0, C_NONE, 1, 0);
        chk("done_vs_timeout_code", o_rt, 2);
        chk("done_vs_timeout_pulse", o_to, 0);
        step(0, 3'd0, C_NONE, 0, 1);
        step(1, 3'd0, C_ITIO, 0, 0);

        // Three completions without acceptance: third request dropped.
        for (int r = 0; r < 3; r++) begin
            step(1, 3'd0, C_START, 0, 0);
            step(0, 3'd0, C_NONE, 1, 0);
            step(1, 3'd0, C_ITIO, 0, 0);
        end
        step(0, 3'd0, C_NONE, 0, 1);
        step(0, 3'd0, C_NONE, 0, 1);
        chk("queue_drop_empty", o_recd, 0);

        // Asynchronous reset while busy with a request pending.
        step(1, 3'd0, C_START, 0, 0);
        step(0, 3'd0, C_NONE, 1, 0);
        step(1, 3'd0, C_ITIO, 0, 0);
        step(1, 3'd0, C_START, 0, 0);
        chk("pre_reset_busy", o_busy, 1);
        chk("pre_reset_recd", o_recd, 1);
        #2 rst_n = 1'b0;
        strobe = 0; cmd = C_NONE; done = 0; adv = 0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        step(1, 3'd0, C_START, 0, 0);
        chk("post_reset_cc", o_cc, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit         rs, rd, ra;
            logic [2:0] rsel;
            logic [4:0] rc;
            rs   = ($urandom_range(0, 2) == 0);
            rsel = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            if ($urandom_range(0, 9) == 0) rc = 5'($urandom_range(0, 31));
            else rc = 5'b00001 << $urandom_range(0, 4);
            rd = ($urandom_range(0, 7) == 0);
            ra = ($urandom_range(0, 3) == 0);
            step(rs, rsel, rc, rd, ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/x2050chrsp.md
Name: x2050chrsp

Overview:
- Channel-side command responder for the 2050 common channel facilities.
- Accepts the decoded I/O command latched by the CPU-side command latch: start io, halt io, test io, test channel, int test io.
- Answers a selected command with a condition code and a one-cycle reply latch pulse.
- Tracks a single subchannel busy/interrupt state with a timeout counter.
- Raises routine requests toward the CPU ROS and holds routine-recd until the request is accepted.

Parameters:
- CH_ID, 3'd0, channel number this responder answers to; compared with i_ch_select.
- TIMEOUT_CYCLES, 16'd255, busy cycles allowed before a timeout.
- RT_END, 4'd2, routine request code for device end.
- RT_TIMEOUT, 4'd3, routine request code for timeout.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_cmd_strobe  in  1  one-cycle pulse; command bits and i_ch_select valid
- i_ch_select  in  3  selected channel number
- i_start_io  in  1  command bit
- i_halt_io  in  1  command bit
- i_test_io  in  1  command bit
- i_test_channel  in  1  command bit
- i_int_test_io  in  1  command bit
- i_ros_advance  in  1  CPU ROS advance; accepts a pending routine request
- i_dev_done  in  1  one-cycle device completion pulse
- o_reply_latch_pulse  out  1  one-cycle reply strobe
- o_cc  out  2  condition code; valid while o_reply_latch_pulse is high
- o_routine_requesting  out  4  routine code; 0 when no request
- o_routine_recd  out  1  request pending; high until accepted
- o_busy  out  1  subchannel busy
- o_int_pending  out  1  interrupt/status pending
- o_timeout_check  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values (i_reset_n low, any time, including mid-operation):
  - state IDLE; counter 0.
  - o_reply_latch_pulse, o_cc, o_busy, o_int_pending, o_timeout_check, o_routine_recd = 0; o_routine_requesting = 0.
- States:
  - IDLE: no operation outstanding.
  - BUSY: counter increments each cycle.
  - REPLY: one cycle; o_reply_latch_pulse = 1, o_cc valid; then returns to IDLE or BUSY.
- Command accept:
  - Ignored entirely unless i_cmd_strobe = 1 and i_ch_select == CH_ID.
  - Reply pulse occurs the cycle after the strobe (latency 1).
- Foul: more than one command bit set, or none set -> cc=3, no state change.
- Condition codes:
  - start io:
    - not busy and no int pending -> cc=0; enter BUSY; counter cleared.
    - int pending -> cc=1.
    - busy -> cc=2.
  - halt io:
    - busy -> abort; set int pending; cc=1.
    - not busy -> cc=0.
  - test io / test channel:
    - int pending -> cc=1; test io also clears int pending; test channel does not.
    - else busy -> cc=2.
    - else cc=0.
  - int test io: int pending -> cc=1 and clear it; else cc=0.
- Busy completion:
  - i_dev_done while busy -> leave BUSY; set int pending; post request RT_END.
  - i_dev_done while not busy is ignored.
- Timeout:
  - Counter reaches TIMEOUT_CYCLES-1 while busy -> o_timeout_check pulses the next cycle.
  - Same cycle as the pulse: leave BUSY, set int pending, post RT_TIMEOUT.
  - Counter width 16; no wrap is possible because the timeout ends BUSY.
- Routine request:
  - Posting sets o_routine_requesting = code and o_routine_recd = 1.
  - Both clear on the cycle after i_ros_advance is sampled with o_routine_recd = 1.
  - A second post while one is pending is held in a one-deep queue and presented after the first is accepted.
  - A third post while the queue is full is dropped; int pending still sets.
- Simultaneous events:
  - i_dev_done or timeout in the same cycle as an accepted command: completion applies first; the command is evaluated against the post-completion state. Example: start io + done -> cc=1.
  - i_dev_done and timeout in the same cycle: done wins; RT_END only.
  - Halt io in the same cycle as done: done wins, cc=1.

Decomposition:
- Shared package x2050_chan_pkg:
  - condition-code constants CC_OK=0, CC_STATUS=1, CC_BUSY=2, CC_NOTOP=3.
  - routine code constants.
  - state enum.
- One sub-module x2050rtq: 2-entry routine request queue with ros_advance handshake; supplies o_routine_requesting and o_routine_recd.

Test Plan:
- Reset, then strobe start io with ch_select=CH_ID -> next cycle reply pulse, cc=0, o_busy=1; repeat start io -> cc=2.
- Busy, then i_dev_done -> o_busy=0, o_int_pending=1, o_routine_requesting=2, o_routine_recd=1; i_ros_advance -> both clear next cycle; test io -> cc=1, int pending cleared.
- start io, no done for 255 cycles -> o_timeout_check pulse at cycle 255, routine code 3, o_busy=0.
- Strobe with ch_select≠CH_ID -> no reply. Strobe with start io+halt io both set -> cc=3, state unchanged.
- start io + i_dev_done in the same cycle while busy -> cc=1; two quick completions without ros_advance -> codes presented in order 2 then 2.
- Drop i_reset_n while BUSY with a request pending -> all outputs 0 immediately; start io afterwards -> cc=0.
